// File: rtl/lv_param_pkg.sv
// rtl/lv_param_pkg.sv - shared defaults, widths and FSM state type for the LV scan register checker
//
// Package lv_param:
//   LV_SCAN_REG_NUM  default number of registers in the LV configuration bank
//   REG_DW           default data width per register
//   BG_PERIOD        default clock cycles between background single-register checks
//   SCAN_IDX_W       width of a register index
//   BG_CNT_W         width of the background period counter
//   lv_scan_chk_st_e checker FSM state encoding

package lv_param;

    localparam int LV_SCAN_REG_NUM = 16;
    localparam int REG_DW          = 8;
    localparam int BG_PERIOD       = 256;

    localparam int SCAN_IDX_W = $clog2(LV_SCAN_REG_NUM);
    localparam int BG_CNT_W   = $clog2(BG_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        BIST_SCAN,
        BG_CHK,
        GAP
    } lv_scan_chk_st_e;

endpackage

// File: rtl/lv_scan_reg_chk_par_chk.sv
// rtl/lv_scan_reg_chk_par_chk.sv - register select mux plus odd-parity compare
//
// Module lv_par_chk (combinational).
// Optional feature macro: LV_SCAN_REG_ERR_INJ_EN (adds err_inj).
// Ports:
//   reg_data  packed register bank, register k at [k*DW +: DW]
//   reg_par   stored odd-parity bit per register
//   idx       index of the register to evaluate
//   err_inj   (LV_SCAN_REG_ERR_INJ_EN only) invert parity of register 0
//   mismatch  1 when the selected register violates odd parity

module lv_par_chk #(
    parameter int NUM   = 16,
    parameter int DW    = 8,
    parameter int IDX_W = $clog2(NUM)
) (
    input  logic [NUM*DW-1:0] reg_data,
    input  logic [NUM-1:0]    reg_par,
    input  logic [IDX_W-1:0]  idx,
`ifdef LV_SCAN_REG_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic              mismatch
);

    logic [DW-1:0] sel_data;
    logic          sel_par;

    assign sel_data = reg_data[idx*DW +: DW];

`ifdef LV_SCAN_REG_ERR_INJ_EN
    assign sel_par = reg_par[idx] ^ (err_inj && (idx == '0));
`else
    assign sel_par = reg_par[idx];
`endif

    // Odd parity holds when data plus parity bit XOR to 1.
    assign mismatch = ~(^{sel_data, sel_par});

endmodule

// File: rtl/lv_scan_reg_chk.sv
// rtl/lv_scan_reg_chk.sv - parity integrity checker for the LV configuration register bank
//
// BIST scan: one register per cycle, level ack for LV_SCAN_REG_NUM cycles with
// per-register err. Background: slow round-robin single-register checks with a
// sticky fault and first-fault index.
// Optional feature macro: LV_SCAN_REG_ERR_INJ_EN (adds i_err_inj).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_reg_data, i_reg_par   register bank and stored odd-parity bits
//   i_bist_scan_reg_req     BIST scan request (level)
//   o_scan_reg_bist_ack     high for LV_SCAN_REG_NUM cycles per scan
//   o_scan_reg_bist_err     parity error of the register reported this ack cycle
//   i_bg_scan_en            background scan enable
//   i_bg_fault_clr          clears the background fault and index
//   o_bg_scan_fault         sticky background parity fault
//   o_bg_fault_idx          index of the first faulting register
//   i_err_inj               (LV_SCAN_REG_ERR_INJ_EN only) invert parity of register 0

module lv_scan_reg_chk
    import lv_param::*;
#(
    parameter int LV_SCAN_REG_NUM = lv_param::LV_SCAN_REG_NUM,
    parameter int REG_DW          = lv_param::REG_DW,
    parameter int BG_PERIOD       = lv_param::BG_PERIOD
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [LV_SCAN_REG_NUM*REG_DW-1:0]  i_reg_data,
    input  logic [LV_SCAN_REG_NUM-1:0]         i_reg_par,
    input  logic                               i_bist_scan_reg_req,
    output logic                               o_scan_reg_bist_ack,
    output logic                               o_scan_reg_bist_err,
    input  logic                               i_bg_scan_en,
    input  logic                               i_bg_fault_clr,
`ifdef LV_SCAN_REG_ERR_INJ_EN
    input  logic                               i_err_inj,
`endif
    output logic                               o_bg_scan_fault,
    output logic [$clog2(LV_SCAN_REG_NUM)-1:0] o_bg_fault_idx
);

    localparam int IDX_W = $clog2(LV_SCAN_REG_NUM);
    localparam int CNT_W = $clog2(BG_PERIOD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LV_SCAN_REG_NUM - 1);
    localparam logic [CNT_W-1:0] DUE_CNT  = CNT_W'(BG_PERIOD - 1);

    lv_scan_chk_st_e  state;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] bg_ptr;
    logic [IDX_W-1:0] chk_idx;
    logic [CNT_W-1:0] bg_cnt;
    logic             bg_due;
    logic             mismatch;

    // One parity checker shared by both paths; scan_idx rests at 0 outside a scan.
    assign chk_idx = (state == BG_CHK) ? bg_ptr : scan_idx;
    assign bg_due  = (bg_cnt == DUE_CNT);

    lv_par_chk #(
        .NUM   (LV_SCAN_REG_NUM),
        .DW    (REG_DW),
        .IDX_W (IDX_W)
    ) u_par_chk (
        .reg_data (i_reg_data),
        .reg_par  (i_reg_par),
        .idx      (chk_idx),
`ifdef LV_SCAN_REG_ERR_INJ_EN
        .err_inj  (i_err_inj),
`endif
        .mismatch (mismatch)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            scan_idx            <= '0;
            bg_ptr              <= '0;
            bg_cnt              <= '0;
            o_scan_reg_bist_ack <= 1'b0;
            o_scan_reg_bist_err <= 1'b0;
            o_bg_scan_fault     <= 1'b0;
            o_bg_fault_idx      <= '0;
        end else begin
            o_scan_reg_bist_ack <= 1'b0;
            o_scan_reg_bist_err <= 1'b0;

            // Saturating period counter; a saturated count is the pending check.
            if (!i_bg_scan_en || state == BG_CHK) begin
                bg_cnt <= '0;
            end else if (!bg_due) begin
                bg_cnt <= bg_cnt + 1'b1;
            end

            // A fault set in BG_CHK below overrides this clear.
            if (i_bg_fault_clr) begin
                o_bg_scan_fault <= 1'b0;
                o_bg_fault_idx  <= '0;
            end

            case (state)
                IDLE: begin
                    if (i_bist_scan_reg_req) begin
                        // Register 0 is reported on the accepting edge so ack follows
                        // the request by one cycle and back-to-back scans leave a
                        // single ack-low cycle (the GAP state).
                        o_scan_reg_bist_ack <= 1'b1;
                        o_scan_reg_bist_err <= mismatch;
                        scan_idx            <= IDX_W'(1);
                        state               <= BIST_SCAN;
                    end else if (bg_due) begin
                        state <= BG_CHK;
                    end
                end
                BIST_SCAN: begin
                    o_scan_reg_bist_ack <= 1'b1;
                    o_scan_reg_bist_err <= mismatch;
                    if (scan_idx == LAST_IDX) begin
                        scan_idx <= '0;
                        state    <= GAP;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                BG_CHK: begin
                    bg_ptr <= (bg_ptr == LAST_IDX) ? '0 : bg_ptr + 1'b1;
                    if (mismatch) begin
                        o_bg_scan_fault <= 1'b1;
                        if (!o_bg_scan_fault || i_bg_fault_clr) begin
                            o_bg_fault_idx <= bg_ptr;
                        end
                    end
                    state <= IDLE;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lv_scan_reg_chk.sv
// tb/tb_lv_scan_reg_chk.sv - self-checking bench for lv_scan_reg_chk

module tb_lv_scan_reg_chk;

    localparam int N      = 16;
    localparam int DW     = 8;
    localparam int PERIOD = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] reg_data;
    logic [N-1:0]    reg_par;
    logic            req;
    logic            ack;
    logic            err;
    logic            bg_en;
    logic            bg_clr;
    logic            err_inj;
    logic            fault;
    logic [3:0]      fault_idx;

    int n_checks = 0;
    int n_fail   = 0;
    bit saw_ack  = 1'b0;

    always #5 clk = ~clk;

    lv_scan_reg_chk dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_reg_data          (reg_data),
        .i_reg_par           (reg_par),
        .i_bist_scan_reg_req (req),
        .o_scan_reg_bist_ack (ack),
        .o_scan_reg_bist_err (err),
        .i_bg_scan_en        (bg_en),
        .i_bg_fault_clr      (bg_clr),
`ifdef LV_SCAN_REG_ERR_INJ_EN
        .i_err_inj           (err_inj),
`endif
        .o_bg_scan_fault     (fault),
        .o_bg_fault_idx      (fault_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rule: odd parity violated (optionally with injected inversion on register 0).
    function automatic logic mism(input int k);
        logic p;
        p = reg_par[k];
        if (k == 0 && err_inj) p = ~p;
        return ~(^{reg_data[k*DW +: DW], p});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_bank(input logic [N-1:0] bad);
        for (int k = 0; k < N; k++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            reg_data[k*DW +: DW] = d;
            reg_par[k] = (~(^d)) ^ bad[k];
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = 1'b0;
        bg_en  = 1'b0;
        bg_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Starts a scan from IDLE and checks every ack cycle; pulse drops req after it is sampled.
    task automatic scan(input bit pulse, input string tag);
        req = 1'b1;
        for (int j = 0; j < N; j++) begin
            tick();
            if (pulse && j == 0) req = 1'b0;
            check($sformatf("%s ack%0d", tag, j), 32'(ack), 32'(1));
            check($sformatf("%s err%0d", tag, j), 32'(err), 32'(mism(j)));
        end
    endtask

    task automatic wait_fault(input int max, output int cyc);
        cyc = 0;
        while (!fault && cyc < max) begin
            tick();
            cyc++;
            if (ack) saw_ack = 1'b1;
        end
    endtask

    initial begin
        int cyc;
        logic [N-1:0] bad;
        bit pulse;

        err_inj  = 1'b0;
        reg_data = '0;
        reg_par  = '1;
        do_reset();

        check("reset ack", 32'(ack), 32'(0));
        check("reset err", 32'(err), 32'(0));
        check("reset fault", 32'(fault), 32'(0));
        check("reset idx", 32'(fault_idx), 32'(0));

        // BIST scans: first two directed (clean pulse, reg5 held), then random.
        for (int it = 0; it < 10; it++) begin
            if (it == 0) begin
                bad = '0;
                pulse = 1'b1;
            end else if (it == 1) begin
                bad = N'(1 << 5);
                pulse = 1'b0;
            end else begin
                bad = N'($urandom & $urandom);
                pulse = 1'($urandom_range(0, 1));
`ifdef LV_SCAN_REG_ERR_INJ_EN
                err_inj = 1'($urandom_range(0, 1));
`endif
            end
            make_bank(bad);
            scan(pulse, $sformatf("it%0d s1", it));
            tick();
            check($sformatf("it%0d gap ack", it), 32'(ack), 32'(0));
            check($sformatf("it%0d gap err", it), 32'(err), 32'(0));
            if (!pulse) begin
                // Request still high: next scan starts right after the single gap cycle.
                scan(1'b1, $sformatf("it%0d s2", it));
                tick();
                check($sformatf("it%0d gap2 ack", it), 32'(ack), 32'(0));
            end
            tick();
            check($sformatf("it%0d idle ack", it), 32'(ack), 32'(0));
        end
        err_inj = 1'b0;

`ifdef LV_SCAN_REG_ERR_INJ_EN
        make_bank('0);
        err_inj = 1'b1;
        scan(1'b1, "inj");
        tick();
        tick();
        err_inj = 1'b0;
`endif

        // Reset at ack cycle 7, then a fresh scan must start from register 0.
        make_bank(N'(1));
        req = 1'b1;
        for (int j = 0; j < 7; j++) tick();
        check("pre-rst ack", 32'(ack), 32'(1));
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst ack", 32'(ack), 32'(0));
        check("mid-rst err", 32'(err), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        scan(1'b1, "post-rst");
        tick();
        tick();

        // Background check due during BIST is deferred to the first request-free IDLE.
        do_reset();
        make_bank(N'(1));
        bg_en = 1'b1;
        repeat (250) tick();
        check("defer pre fault", 32'(fault), 32'(0));
        scan(1'b0, "defer s1");
        tick();
        scan(1'b1, "defer s2");
        tick();
        check("defer gap fault", 32'(fault), 32'(0));
        tick();
        check("defer idle fault", 32'(fault), 32'(0));
        tick();
        check("defer bgchk fault", 32'(fault), 32'(1));
        check("defer bgchk idx", 32'(fault_idx), 32'(0));
        check("defer bgchk ack", 32'(ack), 32'(0));
        check("defer bgchk err", 32'(err), 32'(0));

        // Background round robin with register 3 corrupted.
        do_reset();
        make_bank(N'(1 << 3));
        saw_ack = 1'b0;
        bg_en = 1'b1;
        wait_fault(2000, cyc);
        check("bg fault set", 32'(fault), 32'(1));
        check("bg fault idx", 32'(fault_idx), 32'(3));
        check("bg fault time", 32'(cyc >= 4 * PERIOD && cyc <= 4 * (PERIOD + 2)), 32'(1));
        bg_clr = 1'b1;
        tick();
        bg_clr = 1'b0;
        check("bg clr fault", 32'(fault), 32'(0));
        check("bg clr idx", 32'(fault_idx), 32'(0));
        wait_fault(6000, cyc);
        check("bg refault", 32'(fault), 32'(1));
        check("bg refault idx", 32'(fault_idx), 32'(3));
        check("bg refault time", 32'(cyc > 15 * PERIOD), 32'(1));

        // Register 4 is next; clear lands on the same edge as its failing check.
        reg_par[4] = ~reg_par[4];
        repeat (PERIOD) tick();
        check("bg sticky idx", 32'(fault_idx), 32'(3));
        bg_clr = 1'b1;
        tick();
        bg_clr = 1'b0;
        check("bg clr+set fault", 32'(fault), 32'(1));
        check("bg clr+set idx", 32'(fault_idx), 32'(4));
        check("bg no ack", 32'(saw_ack), 32'(0));

        // Disabling the background scan stops further checks.
        bg_en = 1'b0;
        bg_clr = 1'b1;
        tick();
        bg_clr = 1'b0;
        repeat (2 * PERIOD) tick();
        check("bg disabled fault", 32'(fault), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
